// File: rtl/lut_bank_arbiter.sv
// Four-port, two-bank LUT read arbiter with independent round-robin per bank.
// Ports reading the winner's page in the same bank share that single bank read.
module lut_bank_arbiter #(
  parameter int PAGE_ADDR_BW = 3,
  parameter int DATA_BW      = 3
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    req_a,
  input  logic [PAGE_ADDR_BW-1:0] page_addr_a,
  input  logic                    bank_addr_a,
  input  logic                    req_b,
  input  logic [PAGE_ADDR_BW-1:0] page_addr_b,
  input  logic                    bank_addr_b,
  input  logic                    req_c,
  input  logic [PAGE_ADDR_BW-1:0] page_addr_c,
  input  logic                    bank_addr_c,
  input  logic                    req_d,
  input  logic [PAGE_ADDR_BW-1:0] page_addr_d,
  input  logic                    bank_addr_d,
  output logic                    gnt_a,
  output logic                    gnt_b,
  output logic                    gnt_c,
  output logic                    gnt_d,
  output logic                    bank0_rd_en,
  output logic [PAGE_ADDR_BW-1:0] bank0_page_addr,
  input  logic [DATA_BW-1:0]      bank0_rd_data,
  output logic                    bank1_rd_en,
  output logic [PAGE_ADDR_BW-1:0] bank1_page_addr,
  input  logic [DATA_BW-1:0]      bank1_rd_data,
  output logic                    rd_valid_a,
  output logic                    rd_valid_b,
  output logic                    rd_valid_c,
  output logic                    rd_valid_d,
  output logic [DATA_BW-1:0]      rd_data_a,
  output logic [DATA_BW-1:0]      rd_data_b,
  output logic [DATA_BW-1:0]      rd_data_c,
  output logic [DATA_BW-1:0]      rd_data_d
);

  logic [3:0]                   req;
  logic [3:0]                   bank_sel;
  logic [3:0][PAGE_ADDR_BW-1:0] page;

  assign req      = {req_d, req_c, req_b, req_a};
  assign bank_sel = {bank_addr_d, bank_addr_c, bank_addr_b, bank_addr_a};
  assign page     = {page_addr_d, page_addr_c, page_addr_b, page_addr_a};

  logic [1:0][1:0]              rr_q, rr_d;
  logic [1:0][3:0]              cand;
  logic [1:0]                   win_vld;
  logic [1:0][1:0]              win_idx;
  logic [1:0][PAGE_ADDR_BW-1:0] win_page;
  logic [1:0][3:0]              gnt_bank;
  logic [3:0]                   gnt;

  // NOTE: every variable driven here gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin : arb_comb
    logic [1:0] idx;
    cand     = '0;
    win_vld  = '0;
    win_idx  = '0;
    win_page = '0;
    gnt_bank = '0;
    rr_d     = rr_q;
    idx      = '0;
    for (int n = 0; n < 2; n++) begin
      cand[n] = req & (n == 1 ? bank_sel : ~bank_sel) & {4{~rst}};
      // Scan offsets high to low so the candidate closest to rr_q wins last.
      for (int k = 3; k >= 0; k--) begin
        idx = rr_q[n] + 2'(k);
        if (cand[n][idx]) begin
          win_vld[n] = 1'b1;
          win_idx[n] = idx;
        end
      end
      if (win_vld[n]) begin
        win_page[n] = page[win_idx[n]];
        rr_d[n]     = win_idx[n] + 2'd1;
        for (int i = 0; i < 4; i++) begin
          gnt_bank[n][i] = cand[n][i] && (page[i] == win_page[n]);
        end
      end
    end
  end

  assign gnt             = gnt_bank[0] | gnt_bank[1];
  assign bank0_rd_en     = win_vld[0];
  assign bank1_rd_en     = win_vld[1];
  assign bank0_page_addr = win_page[0];
  assign bank1_page_addr = win_page[1];
  assign {gnt_d, gnt_c, gnt_b, gnt_a} = gnt;

  // Return path: remember which bank each granted port read; the bank answers
  // in the following cycle, so the data mux is driven by registered selects.
  logic [3:0]              valid_q, valid_d;
  logic [3:0]              sel_q, sel_d;
  logic [3:0][DATA_BW-1:0] hold_q, hold_d;
  logic [3:0][DATA_BW-1:0] rd_data;

  always_comb begin
    valid_d = gnt;
    sel_d   = bank_sel;
    rd_data = hold_q;
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i]) rd_data[i] = sel_q[i] ? bank1_rd_data : bank0_rd_data;
    end
    hold_d = rd_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rr_q    <= '0;
      valid_q <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  assign {rd_valid_d, rd_valid_c, rd_valid_b, rd_valid_a} = valid_q;
  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign rd_data_c = rd_data[2];
  assign rd_data_d = rd_data[3];

endmodule

// File: tb/tb_lut_bank_arbiter.sv
// Table-driven bench for lut_bank_arbiter: per-cycle grant/bank checks from a
// vector table, read returns checked against a scoreboard queue.
module tb_lut_bank_arbiter;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a, req_b, req_c, req_d;
  logic [2:0] page_addr_a, page_addr_b, page_addr_c, page_addr_d;
  logic       bank_addr_a, bank_addr_b, bank_addr_c, bank_addr_d;
  logic       gnt_a, gnt_b, gnt_c, gnt_d;
  logic       bank0_rd_en, bank1_rd_en;
  logic [2:0] bank0_page_addr, bank1_page_addr;
  logic [2:0] bank0_rd_data = '0;
  logic [2:0] bank1_rd_data = '0;
  logic       rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d;
  logic [2:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;

  always #5 sys_clk = ~sys_clk;

  lut_bank_arbiter #(.PAGE_ADDR_BW(3), .DATA_BW(3)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req_a(req_a), .page_addr_a(page_addr_a), .bank_addr_a(bank_addr_a),
    .req_b(req_b), .page_addr_b(page_addr_b), .bank_addr_b(bank_addr_b),
    .req_c(req_c), .page_addr_c(page_addr_c), .bank_addr_c(bank_addr_c),
    .req_d(req_d), .page_addr_d(page_addr_d), .bank_addr_d(bank_addr_d),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c), .gnt_d(gnt_d),
    .bank0_rd_en(bank0_rd_en), .bank0_page_addr(bank0_page_addr), .bank0_rd_data(bank0_rd_data),
    .bank1_rd_en(bank1_rd_en), .bank1_page_addr(bank1_page_addr), .bank1_rd_data(bank1_rd_data),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b), .rd_valid_c(rd_valid_c), .rd_valid_d(rd_valid_d),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c), .rd_data_d(rd_data_d)
  );

  // Bank contents: a fixed function of bank and page, distinct between banks.
  function automatic logic [2:0] lut(input logic bank, input logic [2:0] pg);
    logic [2:0] r;
    if (bank) r = pg * 3'd5 + 3'd2;
    else      r = pg * 3'd3 + 3'd1;
    return r;
  endfunction

  always @(posedge sys_clk) begin
    if (bank0_rd_en) bank0_rd_data <= lut(1'b0, bank0_page_addr);
    if (bank1_rd_en) bank1_rd_data <= lut(1'b1, bank1_page_addr);
  end

  typedef struct {
    logic [3:0]      req;
    logic [3:0]      bank;
    logic [3:0][2:0] page;
    logic [3:0]      gnt;
    logic [1:0]      en;
    logic [2:0]      pg0;
    logic [2:0]      pg1;
  } vec_t;

  typedef struct {
    int         cyc;
    int         port;
    logic [2:0] data;
  } sb_t;

  sb_t        sb_q[$];
  logic [2:0] last_data [4];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] bank,
                              input logic [11:0] page, input logic [3:0] gnt,
                              input logic [1:0] en, input logic [2:0] pg0,
                              input logic [2:0] pg1);
    vec_t v;
    v.req = req; v.bank = bank; v.page = page;
    v.gnt = gnt; v.en = en; v.pg0 = pg0; v.pg1 = pg1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v);
    logic [3:0]      exp_valid;
    logic [3:0]      act_valid;
    logic [3:0][2:0] act_data;
    sb_t             e;
    {req_d, req_c, req_b, req_a}                 = v.req;
    {bank_addr_d, bank_addr_c, bank_addr_b, bank_addr_a} = v.bank;
    page_addr_a = v.page[0];
    page_addr_b = v.page[1];
    page_addr_c = v.page[2];
    page_addr_d = v.page[3];
    @(negedge sys_clk);
    check("gnt", 32'({gnt_d, gnt_c, gnt_b, gnt_a}), 32'(v.gnt));
    check("rd_en", 32'({bank1_rd_en, bank0_rd_en}), 32'(v.en));
    check("bank0_page_addr", 32'(bank0_page_addr), 32'(v.pg0));
    check("bank1_page_addr", 32'(bank1_page_addr), 32'(v.pg1));
    exp_valid = '0;
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      exp_valid[e.port] = 1'b1;
      last_data[e.port] = e.data;
    end
    act_valid = {rd_valid_d, rd_valid_c, rd_valid_b, rd_valid_a};
    act_data  = {rd_data_d, rd_data_c, rd_data_b, rd_data_a};
    check("rd_valid", 32'(act_valid), 32'(exp_valid));
    for (int p = 0; p < 4; p++)
      check($sformatf("rd_data_%0d", p), 32'(act_data[p]), 32'(last_data[p]));
    for (int p = 0; p < 4; p++)
      if (v.gnt[p]) sb_q.push_back('{cyc + 1, p, lut(v.bank[p], v.page[p])});
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  vec_t vecs[$];

  initial begin
    for (int p = 0; p < 4; p++) last_data[p] = '0;

    // {req, bank, page(D,C,B,A), gnt, en, pg0, pg1}; bit order is D,C,B,A.
    vecs.push_back(mk(4'b0000, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 2'b00, 3'd0, 3'd0));
    // All four contend for bank0: A,B,C,D in turn, D waits three cycles.
    vecs.push_back(mk(4'b1111, 4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0001, 2'b01, 3'd0, 3'd0));
    vecs.push_back(mk(4'b1110, 4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0010, 2'b01, 3'd1, 3'd0));
    vecs.push_back(mk(4'b1100, 4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0100, 2'b01, 3'd2, 3'd0));
    vecs.push_back(mk(4'b1000, 4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b1000, 2'b01, 3'd3, 3'd0));
    // A and C coalesce on bank1 page 5; rr_1 must then be 1, so B beats A.
    vecs.push_back(mk(4'b0101, 4'b0101, {3'd0, 3'd5, 3'd0, 3'd5}, 4'b0101, 2'b10, 3'd0, 3'd5));
    vecs.push_back(mk(4'b0011, 4'b0011, {3'd0, 3'd0, 3'd3, 3'd6}, 4'b0010, 2'b10, 3'd0, 3'd3));
    vecs.push_back(mk(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 4'b0001, 2'b10, 3'd0, 3'd6));
    // Fairness: A and B re-request bank0 every cycle.
    vecs.push_back(mk(4'b0011, 4'b0000, {3'd0, 3'd0, 3'd4, 3'd1}, 4'b0001, 2'b01, 3'd1, 3'd0));
    vecs.push_back(mk(4'b0011, 4'b0000, {3'd0, 3'd0, 3'd4, 3'd1}, 4'b0010, 2'b01, 3'd4, 3'd0));
    vecs.push_back(mk(4'b0011, 4'b0000, {3'd0, 3'd0, 3'd4, 3'd1}, 4'b0001, 2'b01, 3'd1, 3'd0));
    vecs.push_back(mk(4'b0011, 4'b0000, {3'd0, 3'd0, 3'd4, 3'd1}, 4'b0010, 2'b01, 3'd4, 3'd0));
    // Parallel banks, same page number.
    vecs.push_back(mk(4'b0011, 4'b0010, {3'd0, 3'd0, 3'd2, 3'd2}, 4'b0011, 2'b11, 3'd2, 3'd2));
    // B wins alone, then C wins and coalesces A and D (below and above pointer).
    vecs.push_back(mk(4'b1111, 4'b0000, {3'd6, 3'd6, 3'd7, 3'd6}, 4'b0010, 2'b01, 3'd7, 3'd0));
    vecs.push_back(mk(4'b1101, 4'b0000, {3'd6, 3'd6, 3'd7, 3'd6}, 4'b1101, 2'b01, 3'd6, 3'd0));
    // D loses on bank1, withdraws, then wins from the held pointer.
    vecs.push_back(mk(4'b1100, 4'b1100, {3'd4, 3'd1, 3'd0, 3'd0}, 4'b0100, 2'b10, 3'd0, 3'd1));
    vecs.push_back(mk(4'b0000, 4'b1100, {3'd4, 3'd1, 3'd0, 3'd0}, 4'b0000, 2'b00, 3'd0, 3'd0));
    vecs.push_back(mk(4'b1001, 4'b1001, {3'd4, 3'd0, 3'd0, 3'd0}, 4'b1000, 2'b10, 3'd0, 3'd4));
    // Back-to-back grants to A.
    vecs.push_back(mk(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001, 2'b01, 3'd5, 3'd0));
    vecs.push_back(mk(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd7}, 4'b0001, 2'b01, 3'd7, 3'd0));
    vecs.push_back(mk(4'b0000, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 2'b00, 3'd0, 3'd0));
    vecs.push_back(mk(4'b0000, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 2'b00, 3'd0, 3'd0));

    // Requests held during reset must not be granted.
    run_cycle(mk(4'b1111, 4'b0101, {3'd1, 3'd2, 3'd3, 3'd4}, 4'b0000, 2'b00, 3'd0, 3'd0));
    rst = 1'b0;

    foreach (vecs[i]) run_cycle(vecs[i]);

    // Reset with reads in flight: C on bank0 and B on bank1 granted, then reset.
    run_cycle(mk(4'b0110, 4'b0010, {3'd0, 3'd4, 3'd3, 3'd0}, 4'b0110, 2'b11, 3'd4, 3'd3));
    rst = 1'b1;
    sb_q.delete();
    for (int p = 0; p < 4; p++) last_data[p] = '0;
    run_cycle(mk(4'b1001, 4'b0000, {3'd5, 3'd0, 3'd0, 3'd2}, 4'b0000, 2'b00, 3'd0, 3'd0));
    run_cycle(mk(4'b1001, 4'b0000, {3'd5, 3'd0, 3'd0, 3'd2}, 4'b0000, 2'b00, 3'd0, 3'd0));
    rst = 1'b0;
    // Both pointers restart at 0: A beats D on bank0, B beats C on bank1.
    run_cycle(mk(4'b1111, 4'b0110, {3'd5, 3'd6, 3'd1, 3'd2}, 4'b0011, 2'b11, 3'd2, 3'd1));
    run_cycle(mk(4'b1100, 4'b0110, {3'd5, 3'd6, 3'd1, 3'd2}, 4'b1100, 2'b11, 3'd5, 3'd6));
    run_cycle(mk(4'b0000, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 2'b00, 3'd0, 3'd0));
    run_cycle(mk(4'b0000, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 2'b00, 3'd0, 3'd0));

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
